// File: rtl/i2c_pkg.sv
// Shared command/state encodings and the line-drive decode for the I2C master.
// Keeping the decode here makes the SCL/SDA waveform for every state a single, reviewable table.
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam logic [3:0] LAST_SLOT = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_STOP  = 2'd2,
        ST_BIT   = 2'd3
    } state_t;

    // Returns {scl_oe, sda_oe} for a given state / tick position (1 = pull low).
    function automatic logic [1:0] line_drive(
        input state_t     st,
        input logic [1:0] phase,
        input logic [3:0] slot,
        input logic       data_bit,
        input logic       is_read,
        input logic       ack_bit,
        input logic       idle_scl
    );
        logic scl;
        logic sda;
        scl = 1'b0;
        sda = 1'b0;
        case (st)
            ST_IDLE: begin
                scl = idle_scl;
                sda = 1'b0;
            end
            ST_START: begin
                scl = (phase == 2'd3);
                sda = phase[1];
            end
            ST_STOP: begin
                scl = (phase == 2'd0);
                sda = (phase != 2'd3);
            end
            default: begin
                scl = (phase == 2'd0) || (phase == 2'd3);
                if (slot == LAST_SLOT)
                    sda = is_read ? ~ack_bit : 1'b0;
                else
                    sda = is_read ? 1'b0 : ~data_bit;
            end
        endcase
        return {scl, sda};
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running DW-bit divider; tick pulses for one clk cycle at the last cycle of each bus tick.
// restart realigns the divider so a command's first tick is a full 2^DW cycles long.
module i2c_tick_gen #(
    parameter int DW = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    logic [DW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (restart)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign tick = &cnt_reg;

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master: START/STOP/WRITE/READ commands driven onto open-drain SCL/SDA enables.
// Line enables are registered from next-state values so the pins never glitch on decode.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int DW = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i,
    input  logic [7:0] data_in,
    input  logic       ack_in,
    input  logic [1:0] cmd,
    input  logic       stb,
    output logic [7:0] data_out,
    output logic       ack_out,
    output logic       ready
);

    state_t     state_reg, state_next;
    logic [1:0] phase_reg, phase_next;
    logic [3:0] slot_reg, slot_next;
    logic [7:0] shift_reg, shift_next;
    logic       is_read_reg, is_read_next;
    logic       ack_bit_reg, ack_bit_next;
    logic       idle_scl_reg, idle_scl_next;
    logic       sample_reg, sample_next;
    logic [7:0] data_out_reg, data_out_next;
    logic       ack_out_reg, ack_out_next;
    logic       ready_reg, ready_next;
    logic       scl_reg, scl_next;
    logic       sda_reg, sda_next;
    logic       accept;
    logic       tick;

    i2c_tick_gen #(.DW(DW)) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        slot_next     = slot_reg;
        shift_next    = shift_reg;
        is_read_next  = is_read_reg;
        ack_bit_next  = ack_bit_reg;
        idle_scl_next = idle_scl_reg;
        sample_next   = sample_reg;
        data_out_next = data_out_reg;
        ack_out_next  = ack_out_reg;
        accept        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (stb && ready_reg) begin
                    accept       = 1'b1;
                    phase_next   = 2'd0;
                    slot_next    = 4'd0;
                    shift_next   = data_in;
                    is_read_next = (cmd == CMD_READ);
                    ack_bit_next = ack_in;
                    case (cmd)
                        CMD_START: state_next = ST_START;
                        CMD_STOP:  state_next = ST_STOP;
                        default:   state_next = ST_BIT;
                    endcase
                end
            end
            ST_START, ST_STOP: begin
                if (tick) begin
                    phase_next = phase_reg + 1'b1;
                    if (phase_reg == 2'd3) begin
                        state_next    = ST_IDLE;
                        idle_scl_next = (state_reg == ST_START);
                    end
                end
            end
            default: begin
                if (tick) begin
                    phase_next = phase_reg + 1'b1;
                    // SDA is sampled as SCL is about to be pulled low again.
                    if (phase_reg == 2'd2) begin
                        if (slot_reg == LAST_SLOT)
                            sample_next = sda_i;
                        else if (is_read_reg)
                            shift_next = {shift_reg[6:0], sda_i};
                    end
                    if (phase_reg == 2'd3) begin
                        if (slot_reg == LAST_SLOT) begin
                            state_next    = ST_IDLE;
                            idle_scl_next = 1'b1;
                            if (is_read_reg)
                                data_out_next = shift_reg;
                            else
                                ack_out_next = sample_reg;
                        end else begin
                            slot_next = slot_reg + 4'd1;
                            if (!is_read_reg)
                                shift_next = {shift_reg[6:0], 1'b0};
                        end
                    end
                end
            end
        endcase

        {scl_next, sda_next} = line_drive(state_next, phase_next, slot_next, shift_next[7],
                                          is_read_next, ack_bit_next, idle_scl_next);
        ready_next = (state_next == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            phase_reg    <= 2'd0;
            slot_reg     <= 4'd0;
            shift_reg    <= 8'h00;
            is_read_reg  <= 1'b0;
            ack_bit_reg  <= 1'b0;
            idle_scl_reg <= 1'b0;
            sample_reg   <= 1'b0;
            data_out_reg <= 8'h00;
            ack_out_reg  <= 1'b0;
            ready_reg    <= 1'b0;
            scl_reg      <= 1'b0;
            sda_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            slot_reg     <= slot_next;
            shift_reg    <= shift_next;
            is_read_reg  <= is_read_next;
            ack_bit_reg  <= ack_bit_next;
            idle_scl_reg <= idle_scl_next;
            sample_reg   <= sample_next;
            data_out_reg <= data_out_next;
            ack_out_reg  <= ack_out_next;
            ready_reg    <= ready_next;
            scl_reg      <= scl_next;
            sda_reg      <= sda_next;
        end
    end

    assign scl_oe   = scl_reg;
    assign sda_oe   = sda_reg;
    assign data_out = data_out_reg;
    assign ack_out  = ack_out_reg;
    assign ready    = ready_reg;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: table of commands, per-tick line scoreboard, reset corners.
module tb_i2c_master;

    localparam int DW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_i = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       ack_in = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       stb = 1'b0;
    logic [7:0] data_out;
    logic       ack_out;
    logic       ready;

    always #5 clk = ~clk;

    i2c_master #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_i    (sda_i),
        .data_in  (data_in),
        .ack_in   (ack_in),
        .cmd      (cmd),
        .stb      (stb),
        .data_out (data_out),
        .ack_out  (ack_out),
        .ready    (ready)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       ack;
        logic [8:0] sda_bits;
        bit         stb_mid;
        logic [7:0] exp_dout;
        logic       exp_ack;
        int         exp_low;
        logic       exp_idle_scl;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected {scl_oe, sda_oe} during tick t of a command.
    function automatic logic [1:0] model_tick(input logic [1:0] c, input logic [7:0] d,
                                              input logic a, input int t);
        int s;
        int p;
        logic scl;
        logic sda;
        s = t / 4;
        p = t % 4;
        if (c == 2'b00) begin
            if (t < 2) return 2'b00;
            else if (t == 2) return 2'b01;
            else return 2'b11;
        end else if (c == 2'b01) begin
            if (t == 0) return 2'b11;
            else if (t < 3) return 2'b01;
            else return 2'b00;
        end
        scl = (p == 0) || (p == 3);
        if (s == 8) sda = c[0] ? ~a : 1'b0;
        else        sda = c[0] ? 1'b0 : ~d[7 - s];
        return {scl, sda};
    endfunction

    task automatic run_vec(input string name, input vec_t v);
        int ticks;
        int low;
        logic [1:0] e;
        chk({name, "_ready_before"}, ready, 1);
        ticks = v.cmd[1] ? 36 : 4;
        for (int t = 0; t < ticks; t++)
            exp_q.push_back(model_tick(v.cmd, v.data, v.ack, t));
        cmd     = v.cmd;
        data_in = v.data;
        ack_in  = v.ack;
        sda_i   = v.sda_bits[8];
        stb     = 1'b1;
        @(posedge clk);
        #1;
        stb     = 1'b0;
        data_in = ~v.data;
        ack_in  = ~v.ack;
        low = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (ready) begin
                low = c;
                break;
            end
            if (c % 32 == 2) sda_i = v.sda_bits[8 - c / 32];
            if (v.stb_mid && c == 100) begin
                stb = 1'b1;
                cmd = 2'b01;
            end else begin
                stb = 1'b0;
            end
            if (c % 8 == 4) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_t%0d_scl", name, c / 8), scl_oe, e[1]);
                    chk($sformatf("%s_t%0d_sda", name, c / 8), sda_oe, e[0]);
                end else begin
                    chk($sformatf("%s_extra_tick%0d", name, c / 8), exp_q.size(), 1);
                end
            end
        end
        stb = 1'b0;
        chk({name, "_ready_low_cycles"}, low, v.exp_low);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
        exp_q.delete();
        chk({name, "_data_out"}, data_out, v.exp_dout);
        chk({name, "_ack_out"}, ack_out, v.exp_ack);
        chk({name, "_idle_scl"}, scl_oe, v.exp_idle_scl);
        chk({name, "_idle_sda"}, sda_oe, 0);
        repeat (20) @(negedge clk);
        chk({name, "_hold_scl"}, scl_oe, v.exp_idle_scl);
        chk({name, "_hold_sda"}, sda_oe, 0);
        chk({name, "_hold_dout"}, data_out, v.exp_dout);
        chk({name, "_hold_ready"}, ready, 1);
        $display("%s cmd %0d data %h low %0d data_out %h ack_out %b", name, v.cmd, v.data,
                 low, data_out, ack_out);
    endtask

    initial begin
        //         cmd    data   ack   sda_bits stb_mid dout   ack  low  idle_scl
        vecs[0] = '{2'b00, 8'h00, 1'b0, 9'h1FF, 1'b0, 8'h00, 1'b0, 32,  1'b1};
        vecs[1] = '{2'b10, 8'hA5, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0, 288, 1'b1};
        vecs[2] = '{2'b11, 8'h00, 1'b0, 9'h000, 1'b0, 8'h00, 1'b0, 288, 1'b1};
        vecs[3] = '{2'b10, 8'h3C, 1'b0, 9'h1FF, 1'b0, 8'h00, 1'b1, 288, 1'b1};
        vecs[4] = '{2'b11, 8'h00, 1'b1, 9'h165, 1'b0, 8'hB2, 1'b1, 288, 1'b1};
        vecs[5] = '{2'b10, 8'h5A, 1'b0, 9'h000, 1'b1, 8'hB2, 1'b0, 288, 1'b1};
        vecs[6] = '{2'b01, 8'h00, 1'b0, 9'h1FF, 1'b0, 8'hB2, 1'b0, 32,  1'b0};
        vecs[7] = '{2'b00, 8'h00, 1'b0, 9'h1FF, 1'b0, 8'hB2, 1'b0, 32,  1'b1};

        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_scl", scl_oe, 0);
        chk("reset_sda", sda_oe, 0);
        chk("reset_dout", data_out, 0);
        chk("reset_ack", ack_out, 0);
        chk("reset_ready", ready, 0);
        rst = 1'b1;
        #1 chk("ready_before_edge", ready, 0);
        @(negedge clk);
        chk("ready_after_release", ready, 1);

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset in the middle of a READ must drop everything immediately.
        cmd    = 2'b11;
        ack_in = 1'b0;
        sda_i  = 1'b0;
        stb    = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
        repeat (100) @(negedge clk);
        chk("midread_busy", ready, 0);
        rst = 1'b0;
        #1;
        chk("midread_rst_scl", scl_oe, 0);
        chk("midread_rst_sda", sda_oe, 0);
        chk("midread_rst_dout", data_out, 0);
        chk("midread_rst_ack", ack_out, 0);
        chk("midread_rst_ready", ready, 0);
        @(negedge clk);
        chk("midread_held_ready", ready, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midread_ready_after", ready, 1);
        $display("midread_reset data_out %h ready %b", data_out, ready);

        vecs[0].exp_dout = 8'h00;
        run_vec("recover", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter DW, default 3: tick-divider width; one bus tick = 2^DW clk cycles.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low, 0 releases it (open-drain).
REQ-005 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it.
REQ-006 SHALL have port sda_i, input, 1 bit: sampled SDA line level.
REQ-007 SHALL have port data_in, input, 8 bits: byte to transmit for WRITE.
REQ-008 SHALL have port ack_in, input, 1 bit: ACK bit sent after READ (0 = ACK).
REQ-009 SHALL have port cmd, input, 2 bits: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-010 SHALL have port stb, input, 1 bit: command strobe.
REQ-011 SHALL have port data_out, output, 8 bits: byte received by the last READ.
REQ-012 SHALL have port ack_out, output, 1 bit: SDA sampled in the ACK slot of the last WRITE.
REQ-013 SHALL have port ready, output, 1 bit: 1 when idle and able to accept a command.

Function
REQ-014 SHALL accept a command on a rising clk edge with stb=1 and ready=1, latching cmd, data_in and ack_in; ready SHALL be 0 from the next cycle.
REQ-015 SHALL ignore stb while ready=0; ready=1 with stb=0 leaves the outputs unchanged.
REQ-016 SHALL restart the tick counter to 0 on accept; one tick elapses every 2^DW clk cycles.
REQ-017 START SHALL take 4 ticks: release SDA and SCL for ticks 0-1, set sda_oe=1 for tick 2, then set scl_oe=1 and sda_oe=1 for tick 3.
REQ-018 STOP SHALL take 4 ticks: scl_oe=1 and sda_oe=1 for tick 0, release SCL for ticks 1-2, release SDA for tick 3.
REQ-019 Each bit slot SHALL take 4 ticks: phase 0 SCL low with SDA set; phases 1-2 SCL released; phase 3 SCL low.
REQ-020 SDA SHALL change only during phase 0; sda_i SHALL be sampled at the end of phase 2.
REQ-021 WRITE SHALL be 9 slots (36 ticks): data_in MSB first with sda_oe = ~bit, then slot 9 with SDA released; the sample taken in slot 9 SHALL go to ack_out.
REQ-022 READ SHALL be 9 slots: SDA released for slots 1-8, samples shifted into data_out MSB first; in slot 9, sda_oe = ~ack_in.
REQ-023 data_out SHALL update only when a READ completes; ack_out only when a WRITE completes.
REQ-024 After START, WRITE or READ, the idle state SHALL keep scl_oe=1 and sda_oe=0.
REQ-025 After STOP, the idle state SHALL keep scl_oe=0 and sda_oe=0.
REQ-026 ready SHALL return to 1 on the cycle after the final tick of the command.
REQ-027 SHALL implement no clock stretching or arbitration; SCL is never read back.
REQ-028 The FSM SHALL have states IDLE, START, STOP, BIT; BIT holds a 4-bit slot counter (0-8) and a 2-bit phase counter.

Reset
REQ-029 On rst=0, asynchronously: scl_oe=0, sda_oe=0, data_out=0x00, ack_out=0, ready=0, state IDLE, all counters 0.
REQ-030 ready SHALL go to 1 on the first clk edge after rst is released.
REQ-031 Reset asserted mid-command SHALL abort the command and release both lines immediately.

Structure
REQ-032 Command encodings (CMD_START, CMD_STOP, CMD_WRITE, CMD_READ) and FSM state encodings SHALL be in a shared package i2c_pkg.
REQ-033 A sub-module i2c_tick_gen (DW-bit counter with synchronous restart, one-cycle tick pulse) SHALL generate the ticks; all other logic SHALL be in i2c_master.

Verification
REQ-034 DW=3, START after reset -> ready low for 32 cycles; SDA falls while SCL is released; then scl_oe=1, sda_oe=1.
REQ-035 WRITE 0xA5 with sda_i=0 -> sda_oe per slot 0,1,0,1,1,0,1,0, then 0; ready low for 288 cycles; ack_out=0.
REQ-036 READ with ack_in=0 and sda_i=0 -> data_out=0x00; sda_oe=1 in slot 9; WRITE 0x3C with sda_i=1 -> ack_out=1.
REQ-037 STOP -> final scl_oe=0, sda_oe=0; SDA rises while SCL is released; ready=1.
REQ-038 stb pulsed mid-WRITE -> ignored, command duration unchanged.
REQ-039 rst asserted mid-READ -> outputs reach reset values immediately; ready=1 after release.
